// File: rtl/riscv_writeback_unit.sv
// riscv_writeback_unit
//   Writeback stage with a registered register-file write port. Selects and
//   extends the writeback result, merges long-latency (mul/div) results through
//   a small skid FIFO, and forces a one-cycle pipeline stall when the FIFO head
//   has been blocked by the main pipeline for STARVE_MAX cycles.
//
// Ports
//   i_clk, i_rstn              clock (rising edge), async active-low reset
//   i_valid_w, i_reg_write_w   writeback instruction valid / writes rd
//   i_rd_w, i_result_src_w     destination register, result select
//   i_alu_result_w             ALU result (low bits = load byte offset)
//   i_read_data_w              raw aligned memory word
//   i_pc_plus_4w, i_ext_imm_w  pc+4, extended immediate
//   i_funct3_w                 load size/sign code
//   i_lu_valid/o_lu_ready      long-latency result handshake
//   i_lu_rd, i_lu_result       long-latency destination / result
//   o_stall_w                  forced stall, upstream holds its instruction
//   o_lu_pending               FIFO non-empty
//   o_result_w                 combinational result for forwarding
//   o_rf_we/o_rf_rd/o_rf_wdata registered register-file write port
//
// Handshake: a long-latency result transfers on a cycle where i_lu_valid and
// o_lu_ready are both high. o_lu_ready depends only on FIFO occupancy, never
// on i_lu_valid; the producer holds i_lu_rd/i_lu_result stable until accepted.
module riscv_writeback_unit #(
  parameter int XLEN       = 32,
  parameter int LU_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_valid_w,
  input  logic            i_reg_write_w,
  input  logic [4:0]      i_rd_w,
  input  logic [1:0]      i_result_src_w,
  input  logic [XLEN-1:0] i_alu_result_w,
  input  logic [XLEN-1:0] i_read_data_w,
  input  logic [XLEN-1:0] i_pc_plus_4w,
  input  logic [XLEN-1:0] i_ext_imm_w,
  input  logic [2:0]      i_funct3_w,
  input  logic            i_lu_valid,
  output logic            o_lu_ready,
  input  logic [4:0]      i_lu_rd,
  input  logic [XLEN-1:0] i_lu_result,
  output logic            o_stall_w,
  output logic            o_lu_pending,
  output logic [XLEN-1:0] o_result_w,
  output logic            o_rf_we,
  output logic [4:0]      o_rf_rd,
  output logic [XLEN-1:0] o_rf_wdata
);

  localparam int OFFW = (XLEN == 64) ? 3 : 2;
  localparam int PW   = (LU_DEPTH > 1) ? $clog2(LU_DEPTH) : 1;
  localparam int CW   = $clog2(LU_DEPTH + 1);
  localparam int SW   = $clog2(STARVE_MAX + 1);

  // ---------------------------------------------------------------------------
  // Load alignment and extension
  // ---------------------------------------------------------------------------
  logic [OFFW-1:0] w_off;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_result;

  assign w_off  = i_alu_result_w[OFFW-1:0];
  // Move the addressed byte lane down to bit 0.
  assign w_lane = i_read_data_w >> {w_off, 3'b000};

  always_comb begin
    w_load = i_read_data_w;
    case (i_funct3_w)
      3'b000: w_load = XLEN'($signed(w_lane[7:0]));
      3'b001: w_load = XLEN'($signed(w_lane[15:0]));
      3'b100: w_load = XLEN'(w_lane[7:0]);
      3'b101: w_load = XLEN'(w_lane[15:0]);
      3'b010: begin
        if (XLEN == 64) w_load = XLEN'($signed(w_lane[31:0]));
        else            w_load = i_read_data_w;
      end
      3'b110: begin
        if (XLEN == 64) w_load = XLEN'(w_lane[31:0]);
        else            w_load = i_read_data_w;
      end
      default: w_load = i_read_data_w;
    endcase
  end

  always_comb begin
    w_result = i_alu_result_w;
    case (i_result_src_w)
      2'b00:   w_result = i_alu_result_w;
      2'b01:   w_result = w_load;
      2'b10:   w_result = i_pc_plus_4w;
      default: w_result = i_ext_imm_w;
    endcase
  end

  assign o_result_w = w_result;

  // ---------------------------------------------------------------------------
  // Long-latency skid FIFO
  // ---------------------------------------------------------------------------
  logic [4:0]      r_mem_rd   [LU_DEPTH];
  logic [XLEN-1:0] r_mem_data [LU_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [SW-1:0]   r_starve;
  logic            r_stall;
  logic            r_rf_we;
  logic [4:0]      r_rf_rd;
  logic [XLEN-1:0] r_rf_wdata;

  logic w_empty;
  logic w_full;
  logic w_mw;
  logic w_push;
  logic w_pop;
  logic w_blocked;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(LU_DEPTH));
  assign w_mw      = i_valid_w & i_reg_write_w & ~r_stall;
  assign w_push    = i_lu_valid & ~w_full;
  // Drain whenever the main pipeline leaves the port free; during a forced
  // stall w_mw is already low, so the head always drains then.
  assign w_pop     = ~w_empty & (~w_mw | r_stall);
  assign w_blocked = ~w_empty & w_mw;

  assign o_lu_ready   = ~w_full;
  assign o_lu_pending = ~w_empty;
  assign o_stall_w    = r_stall;

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr]   <= i_lu_rd;
      r_mem_data[r_wr_ptr] <= i_lu_result;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation guard: the stall is raised for the cycle after the
  // STARVE_MAX-th blocked cycle; that cycle pops, which clears the counter and
  // drops the stall again.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (w_pop || w_empty)  r_starve <= '0;
      else if (w_blocked)    r_starve <= r_starve + 1'b1;
      r_stall <= w_blocked && ((r_starve + 1'b1) == SW'(STARVE_MAX));
    end
  end

  // ---------------------------------------------------------------------------
  // Registered register-file write port. rd/wdata hold between writes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rf_we    <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_wdata <= '0;
    end else if (w_mw) begin
      r_rf_we    <= (i_rd_w != 5'd0);
      r_rf_rd    <= i_rd_w;
      r_rf_wdata <= w_result;
    end else if (w_pop) begin
      // An x0 head is consumed but not written.
      r_rf_we    <= (r_mem_rd[r_rd_ptr] != 5'd0);
      r_rf_rd    <= r_mem_rd[r_rd_ptr];
      r_rf_wdata <= r_mem_data[r_rd_ptr];
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  assign o_rf_we    = r_rf_we;
  assign o_rf_rd    = r_rf_rd;
  assign o_rf_wdata = r_rf_wdata;

endmodule

// File: tb/tb_riscv_writeback_unit.sv
module tb_riscv_writeback_unit;
  localparam int XLEN       = 32;
  localparam int LU_DEPTH   = 2;
  localparam int STARVE_MAX = 4;

  // ---------------------------------------------------------------- clock/reset
  logic i_clk = 1'b0;
  logic i_rstn;
  always #5 i_clk = ~i_clk;

  logic            i_valid_w, i_reg_write_w;
  logic [4:0]      i_rd_w;
  logic [1:0]      i_result_src_w;
  logic [XLEN-1:0] i_alu_result_w, i_read_data_w, i_pc_plus_4w, i_ext_imm_w;
  logic [2:0]      i_funct3_w;
  logic            i_lu_valid, o_lu_ready;
  logic [4:0]      i_lu_rd;
  logic [XLEN-1:0] i_lu_result;
  logic            o_stall_w, o_lu_pending;
  logic [XLEN-1:0] o_result_w;
  logic            o_rf_we;
  logic [4:0]      o_rf_rd;
  logic [XLEN-1:0] o_rf_wdata;

  riscv_writeback_unit #(.XLEN(XLEN), .LU_DEPTH(LU_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_valid_w(i_valid_w), .i_reg_write_w(i_reg_write_w), .i_rd_w(i_rd_w),
    .i_result_src_w(i_result_src_w), .i_alu_result_w(i_alu_result_w),
    .i_read_data_w(i_read_data_w), .i_pc_plus_4w(i_pc_plus_4w),
    .i_ext_imm_w(i_ext_imm_w), .i_funct3_w(i_funct3_w),
    .i_lu_valid(i_lu_valid), .o_lu_ready(o_lu_ready), .i_lu_rd(i_lu_rd),
    .i_lu_result(i_lu_result), .o_stall_w(o_stall_w), .o_lu_pending(o_lu_pending),
    .o_result_w(o_result_w), .o_rf_we(o_rf_we), .o_rf_rd(o_rf_rd),
    .o_rf_wdata(o_rf_wdata)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: pending long-latency results as {rd, data}.
  logic [XLEN+4:0] exp_q[$];
  int   m_starve;
  logic m_stall;
  logic m_pushed;

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] data);
    int unsigned off, b, h;
    off = addr % 4;
    b = (data / (32'd1 << (off * 8))) % 256;
    h = (data / (32'd1 << (off * 8))) % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] ref_result();
    case (i_result_src_w)
      2'd0:    return i_alu_result_w;
      2'd1:    return ref_load(i_funct3_w, i_alu_result_w, i_read_data_w);
      2'd2:    return i_pc_plus_4w;
      default: return i_ext_imm_w;
    endcase
  endfunction

  // One cycle: inputs are already driven. Checks combinational outputs, advances
  // the model, waits for the edge and checks the write port.
  task automatic step();
    logic [31:0] res, nd;
    logic        mw, pop, push, nwe;
    logic [4:0]  nrd;
    int          sz;
    #1;
    sz  = exp_q.size();
    res = ref_result();
    chk("result", o_result_w, res);
    chk("lu_ready", o_lu_ready, sz < LU_DEPTH);
    chk("lu_pending", o_lu_pending, sz != 0);
    chk("stall", o_stall_w, m_stall);
    mw   = i_valid_w && i_reg_write_w && !m_stall;
    pop  = (sz != 0) && !mw;
    push = i_lu_valid && (sz < LU_DEPTH);
    nwe = 1'b0; nrd = '0; nd = '0;
    if (mw) begin
      nwe = (i_rd_w != 0); nrd = i_rd_w; nd = res;
    end else if (pop) begin
      nrd = exp_q[0][XLEN+4:XLEN]; nd = exp_q[0][XLEN-1:0]; nwe = (nrd != 0);
    end
    if (sz != 0 && mw) begin
      m_starve++;
      m_stall = (m_starve == STARVE_MAX);
    end else begin
      m_starve = 0;
      m_stall  = 1'b0;
    end
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back({i_lu_rd, i_lu_result});
    m_pushed = push;
    @(posedge i_clk); #1;
    chk("rf_we", o_rf_we, nwe);
    if (nwe) begin
      chk("rf_rd", o_rf_rd, nrd);
      chk("rf_wdata", o_rf_wdata, nd);
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic drive_idle();
    i_valid_w = 0; i_reg_write_w = 0; i_rd_w = 0; i_result_src_w = 0;
    i_alu_result_w = 0; i_read_data_w = 0; i_pc_plus_4w = 0; i_ext_imm_w = 0;
    i_funct3_w = 0; i_lu_valid = 0; i_lu_rd = 0; i_lu_result = 0;
  endtask

  task automatic drive_main(input logic [4:0] rd, input logic [31:0] alu);
    i_valid_w = 1; i_reg_write_w = 1; i_rd_w = rd; i_result_src_w = 2'd0; i_alu_result_w = alu;
  endtask

  task automatic model_reset();
    exp_q.delete(); m_starve = 0; m_stall = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int idx, lu_n, stalls;
    logic was_stall;
    drive_idle();
    model_reset();
    i_rstn = 1'b0;

    // Reset values.
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_we", o_rf_we, 0);
    chk("rst_rd", o_rf_rd, 0);
    chk("rst_wdata", o_rf_wdata, 0);
    chk("rst_stall", o_stall_w, 0);
    chk("rst_pending", o_lu_pending, 0);
    chk("rst_ready", o_lu_ready, 1);
    i_rstn = 1'b1;

    // 1: ALU write.
    drive_main(5'd5, 32'h1234);
    step();
    chk("t1_we", o_rf_we, 1);
    chk("t1_rd", o_rf_rd, 5);
    chk("t1_wdata", o_rf_wdata, 32'h1234);
    drive_idle();

    // 2: load extension.
    i_result_src_w = 2'd1; i_alu_result_w = 32'd3; i_read_data_w = 32'h80FF_0000;
    i_funct3_w = 3'b000; #1; chk("t2_lb", o_result_w, 32'hFFFF_FF80); step();
    i_funct3_w = 3'b100; #1; chk("t2_lbu", o_result_w, 32'h0000_0080); step();
    i_alu_result_w = 32'd2; i_read_data_w = 32'h8001_0000;
    i_funct3_w = 3'b001; #1; chk("t2_lh", o_result_w, 32'hFFFF_8001); step();
    drive_idle();

    // 3: long-latency result on an idle pipeline.
    i_lu_valid = 1; i_lu_rd = 5'd7; i_lu_result = 32'hAA;
    step();
    chk("t3_we_c1", o_rf_we, 0);
    chk("t3_pend_c1", o_lu_pending, 1);
    drive_idle();
    step();
    chk("t3_we_c2", o_rf_we, 1);
    chk("t3_rd_c2", o_rf_rd, 7);
    chk("t3_pend_c2", o_lu_pending, 0);

    // 4: continuous main writes starving three long-latency results.
    idx = 0; lu_n = 0; stalls = 0;
    for (int c = 0; c < 12; c++) begin
      drive_main(5'(10 + idx), 32'h100 + 32'(idx));
      if (lu_n < 3) begin
        i_lu_valid = 1; i_lu_rd = 5'(20 + lu_n); i_lu_result = 32'hC0 + 32'(lu_n);
      end else begin
        i_lu_valid = 0;
      end
      was_stall = m_stall;
      step();
      if (m_pushed) lu_n++;
      if (!was_stall) idx++;
      if (c == 1) chk("t4_ready_full", o_lu_ready, 0);
      if (o_stall_w) stalls++;
    end
    chk("t4_stall_pulses", stalls, 2);
    drive_idle();
    repeat (4) step();
    chk("t4_drained", o_lu_pending, 0);

    // 5: writes to x0.
    drive_main(5'd0, 32'hDEAD);
    step();
    chk("t5_main_x0", o_rf_we, 0);
    drive_idle();
    i_lu_valid = 1; i_lu_rd = 5'd0; i_lu_result = 32'hBEEF;
    step();
    drive_idle();
    step();
    chk("t5_lu_x0_we", o_rf_we, 0);
    chk("t5_lu_x0_pend", o_lu_pending, 0);

    // 6: reset while the FIFO is full and the stall is raised.
    lu_n = 0; idx = 0;
    while (!(m_stall && exp_q.size() == 2) && idx < 20) begin
      drive_main(5'd3, 32'(idx));
      i_lu_valid = (lu_n < 2); i_lu_rd = 5'(25 + lu_n); i_lu_result = 32'(idx);
      step();
      if (m_pushed) lu_n++;
      idx++;
    end
    chk("t6_stall_reached", o_stall_w, 1);
    chk("t6_full_reached", o_lu_ready, 0);
    drive_idle();
    i_rstn = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_stall", o_stall_w, 0);
    chk("t6_rst_pending", o_lu_pending, 0);
    chk("t6_rst_ready", o_lu_ready, 1);
    chk("t6_rst_we", o_rf_we, 0);
    @(posedge i_clk); #3;
    i_rstn = 1'b1;
    repeat (4) step();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      i_valid_w      = ($urandom_range(0, 3) != 0);
      i_reg_write_w  = ($urandom_range(0, 4) != 0);
      i_rd_w         = 5'($urandom_range(0, 31));
      i_result_src_w = 2'($urandom_range(0, 3));
      i_alu_result_w = $urandom;
      i_read_data_w  = $urandom;
      i_pc_plus_4w   = $urandom;
      i_ext_imm_w    = $urandom;
      i_funct3_w     = 3'($urandom_range(0, 7));
      i_lu_valid     = ($urandom_range(0, 2) == 0);
      i_lu_rd        = 5'($urandom_range(0, 31));
      i_lu_result    = $urandom;
      step();
    end
    drive_idle();
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
